// File: rtl/fifo_stream_out.sv
// Read-side stage after a show-ahead FIFO: pops words into a 2-entry skid buffer and frames them as packets.
// Optional FIFO_RD_STATS_EN builds a saturating completed-packet counter on pkt_cnt_o.
module fifo_stream_out #(
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned AWIDTH  = 4,
    parameter int unsigned PKT_LEN = 16
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              fifo_empty_i,
    input  logic [DWIDTH-1:0] fifo_rddata_i,
    output logic              fifo_rd_o,
    output logic [AWIDTH-1:0] fifo_shift_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    output logic              last_o,
    input  logic              ready_i,
    output logic [15:0]       pkt_cnt_o
);

    localparam int unsigned   BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_t;

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] out_q, skid_q;
    logic [BW-1:0]     beat_q;
    logic              run_q;
    logic              pop, accept;
    logic              out_ld, skid_ld, skid_to_out;

    // The FIFO may still sit in its own synchronous reset for the first cycle after release.
    assign pop          = run_q & ~fifo_empty_i & (state_q != ST_TWO);
    assign fifo_rd_o    = pop;
    assign fifo_shift_o = AWIDTH'(1);
    assign valid_o      = (state_q != ST_EMPTY);
    assign accept       = valid_o & ready_i;
    assign data_o       = out_q;
    assign last_o       = valid_o & (beat_q == LAST_BEAT);

    always_comb begin
        state_d     = state_q;
        out_ld      = 1'b0;
        skid_ld     = 1'b0;
        skid_to_out = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (pop) begin
                    state_d = ST_ONE;
                    out_ld  = 1'b1;
                end
            end
            ST_ONE: begin
                if (pop && accept) begin
                    out_ld = 1'b1;
                end else if (pop) begin
                    state_d = ST_TWO;
                    skid_ld = 1'b1;
                end else if (accept) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (accept) begin
                    state_d     = ST_ONE;
                    skid_to_out = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            beat_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (skid_to_out) begin
                out_q <= skid_q;
            end else if (out_ld) begin
                out_q <= fifo_rddata_i;
            end
            if (skid_ld) begin
                skid_q <= fifo_rddata_i;
            end
            if (accept) begin
                beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
            end
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [15:0] pkt_cnt_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            pkt_cnt_q <= '0;
        end else if (accept && last_o && (pkt_cnt_q != '1)) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end

    assign pkt_cnt_o = pkt_cnt_q;
`else
    assign pkt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// Bench for fifo_stream_out: show-ahead FIFO model plus word-order/packet reference model.
// Two DUTs share the FIFO: PKT_LEN=4 (drives the FIFO model) and PKT_LEN=1.
module tb_fifo_stream_out;

    localparam int unsigned P0 = 4;
`ifdef FIFO_RD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        arst_n_i = 1'b1;
    logic        fifo_empty_i = 1'b1;
    logic [7:0]  fifo_rddata_i = '0;
    logic        ready_i = 1'b0;
    logic        fifo_rd_o, valid_o, last_o;
    logic [3:0]  fifo_shift_o;
    logic [7:0]  data_o;
    logic [15:0] pkt_cnt_o;
    logic        rd1, valid1, last1;
    logic [3:0]  shift1;
    logic [7:0]  data1;
    logic [15:0] pkt1;

    fifo_stream_out #(.DWIDTH(8), .AWIDTH(4), .PKT_LEN(P0)) u_dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .fifo_empty_i(fifo_empty_i),
        .fifo_rddata_i(fifo_rddata_i), .fifo_rd_o(fifo_rd_o), .fifo_shift_o(fifo_shift_o),
        .data_o(data_o), .valid_o(valid_o), .last_o(last_o), .ready_i(ready_i),
        .pkt_cnt_o(pkt_cnt_o)
    );

    fifo_stream_out #(.DWIDTH(8), .AWIDTH(4), .PKT_LEN(1)) u_dut1 (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .fifo_empty_i(fifo_empty_i),
        .fifo_rddata_i(fifo_rddata_i), .fifo_rd_o(rd1), .fifo_shift_o(shift1),
        .data_o(data1), .valid_o(valid1), .last_o(last1), .ready_i(ready_i),
        .pkt_cnt_o(pkt1)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int errors  = 0;

    // Reference state: words in the FIFO, and words popped by the DUT but not yet delivered.
    logic [7:0] fifo_q[$];
    logic [7:0] ref_q[$];
    int  beat_m, pkt_m, pkt1_m, n_acc;
    bit  run_m, prev_hold;
    logic [7:0] prev_d;

    logic        s_rd, s_valid, s_last, s_last1, s_acc;
    logic [7:0]  s_data;
    logic [15:0] s_pkt, s_pkt1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        ref_q.delete();
        beat_m    = 0;
        pkt_m     = 0;
        pkt1_m    = 0;
        run_m     = 1'b0;
        prev_hold = 1'b0;
    endtask

    task automatic tick();
        logic exp_rd, exp_v;
        fifo_empty_i  = (fifo_q.size() == 0);
        fifo_rddata_i = fifo_empty_i ? 8'h00 : fifo_q[0];
        #1;
        s_rd = fifo_rd_o; s_valid = valid_o; s_data = data_o; s_last = last_o;
        s_last1 = last1; s_pkt = pkt_cnt_o; s_pkt1 = pkt1;
        s_acc = valid_o & ready_i;
        exp_v  = (ref_q.size() != 0);
        exp_rd = run_m && (fifo_q.size() != 0) && (ref_q.size() < 2);
        chk("rd", s_rd, exp_rd);
        chk("rd_when_empty", s_rd & fifo_empty_i, 0);
        chk("valid", s_valid, exp_v);
        if (exp_v) chk("data", s_data, ref_q[0]);
        chk("last", s_last, exp_v && ((beat_m % P0) == P0 - 1));
        chk("pkt", s_pkt, STATS ? pkt_m : 0);
        chk("rd1", rd1, exp_rd);
        chk("valid1", valid1, exp_v);
        if (exp_v) chk("data1", data1, ref_q[0]);
        chk("last1", s_last1, exp_v);
        chk("pkt1", s_pkt1, STATS ? pkt1_m : 0);
        if (prev_hold) begin
            chk("hold_valid", s_valid, 1);
            chk("hold_data", s_data, prev_d);
        end
        prev_hold = s_valid & ~ready_i;
        prev_d    = s_data;
        @(posedge clk_i);
        if (!arst_n_i) begin
            model_reset();
        end else begin
            if (s_rd && fifo_q.size() != 0) ref_q.push_back(fifo_q.pop_front());
            if (s_acc && ref_q.size() != 0) begin
                void'(ref_q.pop_front());
                if ((beat_m % P0) == P0 - 1 && pkt_m < 65535) pkt_m++;
                if (pkt1_m < 65535) pkt1_m++;
                beat_m++;
                n_acc++;
            end
            run_m = 1'b1;
            chk("held_le2", ref_q.size() <= 2, 1);
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        arst_n_i = 1'b0;
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_rd", fifo_rd_o, 0);
        chk("rst_pkt", pkt_cnt_o, 0);
        chk("rst_valid1", valid1, 0);
        chk("rst_last1", last1, 0);
        chk("shift", fifo_shift_o, 1);
        chk("shift1", shift1, 1);
        model_reset();
        repeat (n) tick();
        arst_n_i = 1'b1;
    endtask

    initial begin
        int k, pops, pushed, n_start;
        logic lasts[10];
        logic lasts1[10];
        logic [7:0] first_d;
        n_acc = 0;
        model_reset();

        // 1: three words waiting across reset release, ready held high
        fifo_q.push_back(8'hA1); fifo_q.push_back(8'hB2); fifo_q.push_back(8'hC3);
        ready_i = 1'b1;
        #2;
        do_reset(3);
        tick(); chk("t1_rd_before_run", s_rd, 0);
        tick(); chk("t1_first_pop", s_rd, 1); chk("t1_not_valid_yet", s_valid, 0);
        tick(); chk("t1_A_valid", s_valid, 1); chk("t1_A", s_data, 8'hA1);
        tick(); chk("t1_B", s_data, 8'hB2);
        tick(); chk("t1_C", s_data, 8'hC3);
        tick(); chk("t1_valid_drop", s_valid, 0);

        // 2: five words, consumer stalled, then released
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) fifo_q.push_back(8'h10 + 8'(i));
        pops = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) chk("t2_latency_v0", s_valid, 0);
            if (i == 1) chk("t2_latency_v1", s_valid, 1);
            if (s_rd) pops++;
        end
        chk("t2_pops", pops, 2);
        chk("t2_held", ref_q.size(), 2);
        chk("t2_data_held", s_data, 8'h10);
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_acc", s_acc, 1);
            chk("t2_order", s_data, 8'h10 + 8'(i));
        end
        tick(); chk("t2_drained", s_valid, 0);

        // 3: 1000 random words, random ready and random FIFO fill
        pushed = 0;
        n_start = n_acc;
        for (int cyc = 0; cyc < 20000 && (n_acc - n_start) < 1000; cyc++) begin
            if (pushed < 1000 && fifo_q.size() < 16 && $urandom_range(0, 1) == 1) begin
                fifo_q.push_back(8'($urandom_range(0, 255)));
                pushed++;
            end
            ready_i = ($urandom_range(0, 1) == 1);
            tick();
        end
        chk("t3_words", n_acc - n_start, 1000);

        // 4 and 6: packet framing from a fresh reset
        ready_i = 1'b1;
        do_reset(2);
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'h40 + 8'(i));
        k = 0;
        for (int cyc = 0; cyc < 100 && k < 10; cyc++) begin
            tick();
            if (s_acc) begin
                lasts[k] = s_last;
                lasts1[k] = s_last1;
                k++;
            end
        end
        chk("t4_beats", k, 10);
        for (int i = 0; i < 10; i++) chk($sformatf("t4_last%0d", i), lasts[i], (i == 3 || i == 7));
        for (int i = 0; i < 3; i++) chk($sformatf("t6_last1_%0d", i), lasts1[i], 1);
        tick();
        chk("t4_pkt", s_pkt, STATS ? 2 : 0);
        chk("t6_pkt1", s_pkt1, STATS ? 10 : 0);

        // 5: reset while two words are held and beat_cnt sits on the final beat
        do_reset(1);
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'h50 + 8'(i));
        k = 0;
        for (int cyc = 0; cyc < 50 && k < 3; cyc++) begin
            tick();
            if (s_acc) k++;
        end
        chk("t5_pre_beats", k, 3);
        ready_i = 1'b0;
        repeat (3) tick();
        chk("t5_two_held", ref_q.size(), 2);
        arst_n_i = 1'b0;
        #1;
        chk("t5_valid_async", valid_o, 0);
        chk("t5_last_async", last_o, 0);
        chk("t5_valid1_async", valid1, 0);
        chk("t5_last1_async", last1, 0);
        model_reset();
        tick();
        arst_n_i = 1'b1;
        ready_i  = 1'b1;
        k = 0;
        first_d = '0;
        for (int cyc = 0; cyc < 50 && k < 4; cyc++) begin
            tick();
            if (s_acc) begin
                if (k == 0) first_d = s_data;
                lasts[k] = s_last;
                k++;
            end
        end
        chk("t5_post_beats", k, 4);
        chk("t5_no_rewind", first_d, 8'h55);
        for (int i = 0; i < 4; i++) chk($sformatf("t5_last%0d", i), lasts[i], (i == 3));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
